// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the memory copy engine.
package mem_copy_pkg;

  // Copy engine sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int         WORD_BYTES      = 4;
  localparam int         ADDR_LSB        = $clog2(WORD_BYTES);
  localparam logic [3:0] FULL_WRITE_MASK = 4'b1111;

  // Expand a word index into a word-aligned byte address.
  function automatic logic [31:0] word_to_byte_addr(input logic [31-ADDR_LSB:0] word_idx);
    return {word_idx, {ADDR_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_copy_engine_bus_watchdog.sv
// bus_watchdog: counts cycles an initiator spends waiting for ready and
// flags expiry on the cycle that would be the TIMEOUT_CYCLES-th wait.
// Used by mem_copy_engine only when MEM_COPY_TIMEOUT_EN is defined, but
// kept generic so other bus initiators can reuse it.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic waiting,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  // Wait counter: restarts whenever no access is pending or one completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (waiting) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Expire while waiting on the last permitted cycle so the caller can
  // leave the access at this edge.
  assign expire = waiting && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus initiator copying a block of 32-bit words from a
// source range to a destination range, one read then one write per word.
// Optional build macro MEM_COPY_TIMEOUT_EN adds a per-access ready timeout
// (TIMEOUT_CYCLES) that aborts the copy and flags error_out with done_out.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int LEN_WIDTH = 16
`ifdef MEM_COPY_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_in,
  input  logic [31:0]          src_in,
  input  logic [31:0]          dst_in,
  input  logic [LEN_WIDTH-1:0] len_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic [31:0]          address_out,
  output logic                 sel_out,
  output logic                 read_out,
  input  logic [31:0]          read_value_in,
  output logic [3:0]           write_mask_out,
  output logic [31:0]          write_value_out,
  input  logic                 ready_in
);

  state_t                state_reg, state_next;
  logic [31-ADDR_LSB:0]  src_reg, src_next;
  logic [31-ADDR_LSB:0]  dst_reg, dst_next;
  logic [LEN_WIDTH-1:0]  count_reg, count_next;
  logic [31:0]           data_reg, data_next;
  logic                  timeout_hit;

  // Byte-offset bits of the addresses are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_in[ADDR_LSB-1:0], dst_in[ADDR_LSB-1:0]};

`ifdef MEM_COPY_TIMEOUT_EN
  logic error_reg, error_next;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (!sel_out || ready_in),
    .waiting(sel_out && !ready_in),
    .expire (timeout_hit)
  );

  // Abort flag: remembered from the expiring access until FIN reports it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_reg <= 1'b0;
    end else begin
      error_reg <= error_next;
    end
  end

  assign error_out = (state_reg == FIN) && error_reg;
`else
  assign timeout_hit = 1'b0;
  assign error_out   = 1'b0;
`endif

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      count_reg <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      count_reg <= count_next;
      data_reg  <= data_next;
    end
  end

  // Next-state and bus outputs; bus outputs depend only on registers so a
  // combinational ready_in from the responder cannot form a loop.
  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    count_next      = count_reg;
    data_next       = data_reg;
`ifdef MEM_COPY_TIMEOUT_EN
    error_next      = error_reg;
`endif
    busy_out        = 1'b0;
    done_out        = 1'b0;
    sel_out         = 1'b0;
    read_out        = 1'b0;
    write_mask_out  = 4'b0000;
    write_value_out = '0;
    address_out     = '0;

    case (state_reg)
      IDLE: begin
        if (start_in) begin
          src_next   = src_in[31:ADDR_LSB];
          dst_next   = dst_in[31:ADDR_LSB];
          count_next = len_in;
          state_next = (len_in == '0) ? FIN : RD;
        end
      end

      RD: begin
        busy_out    = 1'b1;
        sel_out     = 1'b1;
        read_out    = 1'b1;
        address_out = word_to_byte_addr(src_reg);
        if (ready_in) begin
          data_next  = read_value_in;
          state_next = WR;
        end else if (timeout_hit) begin
`ifdef MEM_COPY_TIMEOUT_EN
          error_next = 1'b1;
`endif
          state_next = FIN;
        end
      end

      WR: begin
        busy_out        = 1'b1;
        sel_out         = 1'b1;
        write_mask_out  = FULL_WRITE_MASK;
        write_value_out = data_reg;
        address_out     = word_to_byte_addr(dst_reg);
        if (ready_in) begin
          // Word-index arithmetic wraps naturally across the top of memory.
          src_next   = src_reg + 1'b1;
          dst_next   = dst_reg + 1'b1;
          count_next = count_reg - 1'b1;
          state_next = (count_reg == LEN_WIDTH'(1)) ? FIN : RD;
        end else if (timeout_hit) begin
`ifdef MEM_COPY_TIMEOUT_EN
          error_next = 1'b1;
`endif
          state_next = FIN;
        end
      end

      FIN: begin
        done_out   = 1'b1;
`ifdef MEM_COPY_TIMEOUT_EN
        error_next = 1'b0;
`endif
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Memory-bus initiator that copies a block of 32-bit words from a source address range to a destination address range.
- Drives the same sel/read/write_mask/ready bus that the timer, RAM and peripheral responders implement.
- Sits beside the CPU core on the bus arbiter's second initiator port.
- Started by a one-cycle command from a control register block; reports busy/done.

Parameters:
- LEN_WIDTH, 16, width of word-count field; max transfer 2^LEN_WIDTH-1 words.
- TIMEOUT_CYCLES, 255, cycles a bus access may wait for ready_in before abort; only used with MEM_COPY_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_in  in  1  one-cycle command strobe.
- src_in  in  32  source byte address; bits [1:0] ignored.
- dst_in  in  32  destination byte address; bits [1:0] ignored.
- len_in  in  LEN_WIDTH  number of words to copy.
- busy_out  out  1  high from accepted start until done.
- done_out  out  1  one-cycle completion pulse.
- error_out  out  1  one-cycle pulse coincident with done_out on timeout abort.
- address_out  out  32  bus address, always word-aligned.
- sel_out  out  1  bus select.
- read_out  out  1  read strobe.
- read_value_in  in  32  read data, valid when sel_out && ready_in.
- write_mask_out  out  4  byte-write enables.
- write_value_out  out  32  write data.
- ready_in  in  1  responder ready; may be combinational (same-cycle) from sel_out.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; internal src/dst/count/data regs 0. Reset mid-transfer abandons the access immediately; no done_out.
- Bus rule: an access completes on the rising edge where sel_out && ready_in. Address, read, mask and value are held stable from sel_out rise until completion.
- IDLE:
  - sel_out=0, busy_out=0.
  - start_in=1: latch src[31:2], dst[31:2], len.
  - len==0: go to FIN. Otherwise go to RD.
- RD:
  - sel_out=1, read_out=1, write_mask_out=0, address_out={src,2'b00}.
  - On ready_in: capture read_value_in into data reg; go to WR.
- WR:
  - sel_out=1, read_out=0, write_mask_out=4'b1111, write_value_out=data reg, address_out={dst,2'b00}.
  - On ready_in: src+=1, dst+=1 (word units, modulo 2^30, so 0xFFFFFFFC wraps to 0x00000000), count-=1.
  - If count becomes 0, go to FIN; else go to RD.
- FIN: done_out=1 for exactly one cycle, sel_out=0, busy_out=0; next cycle IDLE.
- busy_out is 1 in RD and WR only.
- start_in while not IDLE (including FIN) is ignored.
- Throughput with zero-wait responder: 2 cycles per word. Latency from start_in to done_out = 2*len+1 cycles (len>0); 1 cycle for len=0.
- Overlapping src/dst ranges: copied strictly ascending; no overlap correction.

Optional Feature:
- Macro: MEM_COPY_TIMEOUT_EN.
- With macro:
  - Wait counter clears on entry to RD/WR and increments each cycle sel_out && !ready_in.
  - When it reaches TIMEOUT_CYCLES: drop sel_out and go to FIN; error_out=1 together with done_out; remaining words are not copied.
- Without macro: waits indefinitely; error_out tied 0; no counter logic.

Decomposition:
- Package mem_copy_pkg: state enum (IDLE, RD, WR, FIN), WORD_BYTES=4, FULL_WRITE_MASK=4'b1111.
- Sub-module bus_watchdog (counter + expire flag, parameterised by TIMEOUT_CYCLES). Instantiated only under MEM_COPY_TIMEOUT_EN; reusable by other initiators.

Test Plan:
- Zero-wait RAM model, src=0x1000, dst=0x2000, len=4, source words 0xA0..0xA3 -> 0x2000..0x200C hold 0xA0..0xA3; done_out exactly 9 cycles after start; busy_out high 8 cycles.
- Responder inserting 3 wait cycles per access, len=2 -> address/mask/value stable during waits; done after 2*2*4+1=17 cycles; data correct.
- len=0 -> no sel_out ever; done_out one cycle after start.
- src=0xFFFFFFF8, len=3 -> reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Also src=0x1003 -> first read at 0x1000.
- Assert reset_n=0 during second WR of len=4, then start new copy -> outputs 0 asynchronously, no done_out; new copy runs correctly. start_in pulses while busy -> ignored.
- MEM_COPY_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready_in stuck 0 -> sel_out drops after 8 waiting cycles; done_out and error_out pulse together; without macro, sel_out stays asserted.
